lfsr_symbol_gen: RTL and testbench
==================================

Name: lfsr_symbol_gen

Overview:
Parametrised successor to the game's 8-bit free-running LFSR, sitting between the game controller and the sequence/colour logic. It produces an LFSR state word and delivers multi-step decorrelated random symbols through a req/busy/sym_valid handshake. It also supports runtime seed load and all-zero lockup recovery. An optional compile-time feature adds mark/replay so the controller can regenerate an identical symbol sequence.

Parameters:
WIDTH, 8, LFSR state width (>=3)
TAPS, 8'hB8, feedback mask [WIDTH-1:0]; fb = XOR of state bits where TAPS bit is 1 (default = bits 7,5,4,3)
SEED, 8'hA1, reset/recovery state [WIDTH-1:0]; must be nonzero
SYM_BITS, 2, symbol width (<= WIDTH)
STEPS, 4, shifts per symbol request (1..255)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active high
tick  in  1  single free-running advance when FSM is IDLE
load  in  1  load load_value into state
load_value  in  WIDTH  seed value for load
req  in  1  symbol request; sampled only in IDLE
busy  out  1  high while FSM is in STEP
sym_valid  out  1  one-cycle pulse; sym is new
sym  out  SYM_BITS  last symbol; held until next sym_valid
state_out  out  WIDTH  current LFSR state register
lockup  out  1  one-cycle pulse; all-zero state was replaced by SEED
mark  in  1  (LFSR_REPLAY_EN only) save state to shadow
replay  in  1  (LFSR_REPLAY_EN only) restore state from shadow

Behaviour:
- Shift: next = {fb, state[WIDTH-1:1]}, where fb = ^(state & TAPS).
- Reset (rst=1 at an edge) sets: state=SEED, FSM=IDLE, step count=0, sym=0, sym_valid=0, busy=0, lockup=0, shadow=SEED. Reset overrides every other input.
- FSM has two states, IDLE and STEP.
  - IDLE + req: go to STEP, clear count. tick is not applied on this edge.
  - IDLE + tick, no req: one shift, stay in IDLE.
  - STEP: one shift per cycle; req and tick ignored.
  - On the STEPS-th shift edge: sym <= new_state[SYM_BITS-1:0], sym_valid=1, FSM -> IDLE.
- Latency: req accepted at edge k gives shifts at edges k+1..k+STEPS. sym_valid is high for the cycle after edge k+STEPS. busy is high for exactly STEPS cycles.
- Back-to-back: req high in the sym_valid cycle is accepted, since the FSM is already IDLE.
- load: priority below rst only.
  - state <= load_value.
  - Aborts any STEP in progress: FSM -> IDLE, no sym_valid, sym unchanged.
  - tick and req on the same edge are ignored.
- Lockup: whenever the value about to be written to state (from shift, load or replay) is all-zero, SEED is written instead and lockup=1 for one cycle. With non-primitive TAPS this can occur from a shift (e.g. state=1 with TAPS[0]=0).
- sym_valid and lockup default to 0 every cycle unless set as above.
- state_out is the register itself; no combinational path from any input.

Optional Feature:
Macro LFSR_REPLAY_EN.
- Defined:
  - mark/replay ports and the WIDTH-bit shadow register exist.
  - mark: shadow <= state (the pre-edge value).
  - replay: state <= shadow and aborts STEP like load, with the same lockup rule.
  - Priority: rst > load > replay > mark. mark and replay on the same edge: replay wins, shadow unchanged.
  - mark during STEP is allowed and does not disturb the request.
- Undefined: ports, shadow and logic are absent; the block behaves exactly as described above.

Test Plan:
- Reset with defaults -> state_out=0xA1, sym=0, busy=0, sym_valid=0, lockup=0.
- tick x4 from reset -> state_out 0x50, 0xA8, 0xD4, 0x6A on successive cycles.
- req pulse from reset -> busy high 4 cycles, state_out reaches 0x6A, sym_valid one cycle with sym=2'b10; ticks during busy do not add shifts.
- load=1, load_value=0x00 -> state_out=0xA1, lockup one cycle. Repeat with load_value=0x3C during STEP -> state_out=0x3C, no sym_valid, FSM IDLE.
- Simultaneous rst+load+req -> reset values win; req held high after rst deasserts -> back-to-back symbols every 5 cycles.
- (LFSR_REPLAY_EN) mark at reset, issue 3 reqs (capture syms), replay, issue 3 reqs -> identical sym sequence; mark+replay same edge -> shadow stays 0xA1.

Source files
------------

// File: rtl/lfsr_symbol_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_symbol_gen
// Brief    : Galois-free Fibonacci LFSR with multi-step symbol requests, seed
//            load, all-zero lockup recovery; optional mark/replay when the
//            macro LFSR_REPLAY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_symbol_gen #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
  parameter logic [WIDTH-1:0] SEED    = 8'hA1,
  parameter int              SYM_BITS = 2,
  parameter int              STEPS    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_value,
  input  logic                req,
`ifdef LFSR_REPLAY_EN
  input  logic                mark,
  input  logic                replay,
`endif
  output logic                busy,
  output logic                sym_valid,
  output logic [SYM_BITS-1:0] sym,
  output logic [WIDTH-1:0]    state_out,
  output logic                lockup
);

  localparam logic [7:0] C_LAST = 8'(STEPS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_STEP = 1'b1
  } fsm_e;

  fsm_e                fsm_q;
  logic [WIDTH-1:0]    lfsr_q;
  logic [7:0]          cnt_q;
  logic [SYM_BITS-1:0] sym_q;
  logic                sym_valid_q;
  logic                busy_q;
  logic                lockup_q;

  logic                fb;
  logic [WIDTH-1:0]    shift_raw;
  logic                shift_zero;
  logic [WIDTH-1:0]    shift_d;
  logic                load_zero;
  logic [WIDTH-1:0]    load_d;

  // Any all-zero candidate is replaced by SEED so the register can never lock.
  assign fb         = ^(lfsr_q & TAPS);
  assign shift_raw  = {fb, lfsr_q[WIDTH-1:1]};
  assign shift_zero = (shift_raw == '0);
  assign shift_d    = shift_zero ? SEED : shift_raw;
  assign load_zero  = (load_value == '0);
  assign load_d     = load_zero ? SEED : load_value;

`ifdef LFSR_REPLAY_EN
  logic [WIDTH-1:0] shadow_q;
  logic             replay_zero;
  logic [WIDTH-1:0] replay_d;

  assign replay_zero = (shadow_q == '0);
  assign replay_d    = replay_zero ? SEED : shadow_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= SEED;
      fsm_q       <= S_IDLE;
      cnt_q       <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      lockup_q    <= 1'b0;
`ifdef LFSR_REPLAY_EN
      shadow_q    <= SEED;
`endif
    end else begin
      sym_valid_q <= 1'b0;
      lockup_q    <= 1'b0;
      if (load) begin
        lfsr_q   <= load_d;
        lockup_q <= load_zero;
        fsm_q    <= S_IDLE;
        busy_q   <= 1'b0;
        cnt_q    <= '0;
      end
`ifdef LFSR_REPLAY_EN
      else if (replay) begin
        lfsr_q   <= replay_d;
        lockup_q <= replay_zero;
        fsm_q    <= S_IDLE;
        busy_q   <= 1'b0;
        cnt_q    <= '0;
      end
`endif
      else begin
`ifdef LFSR_REPLAY_EN
        if (mark) begin
          shadow_q <= lfsr_q;
        end
`endif
        case (fsm_q)
          S_IDLE: begin
            if (req) begin
              fsm_q  <= S_STEP;
              busy_q <= 1'b1;
              cnt_q  <= '0;
            end else if (tick) begin
              lfsr_q   <= shift_d;
              lockup_q <= shift_zero;
            end
          end
          S_STEP: begin
            lfsr_q   <= shift_d;
            lockup_q <= shift_zero;
            if (cnt_q == C_LAST) begin
              sym_q       <= shift_d[SYM_BITS-1:0];
              sym_valid_q <= 1'b1;
              fsm_q       <= S_IDLE;
              busy_q      <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: begin
            fsm_q  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign sym_valid = sym_valid_q;
  assign sym       = sym_q;
  assign state_out = lfsr_q;
  assign lockup    = lockup_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_symbol_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_symbol_gen
// Brief    : Directed bench for lfsr_symbol_gen with a sym_valid scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_symbol_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic       req = 1'b0;
`ifdef LFSR_REPLAY_EN
  logic       mark = 1'b0;
  logic       replay = 1'b0;
`endif
  logic       busy;
  logic       sym_valid;
  logic [1:0] sym;
  logic [7:0] state_out;
  logic       lockup;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [1:0] exp_q[$];

  lfsr_symbol_gen dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .req        (req),
`ifdef LFSR_REPLAY_EN
    .mark       (mark),
    .replay     (replay),
`endif
    .busy       (busy),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .state_out  (state_out),
    .lockup     (lockup)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every sym_valid pulse consumes one expected symbol.
  always @(negedge clk) begin
    if (sym_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sym_valid: got sym %0h with nothing expected", sym);
      end else begin
        chk("sym", 32'(sym), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1, "timeout");
  end

`ifdef LFSR_REPLAY_EN
  task automatic run_three_reqs();
    logic [1:0] seq [3];
    seq = '{2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(seq[i]);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask
`endif

  initial begin
    logic [7:0] tick_exp [4];
    logic [1:0] b2b_exp [3];
    int bc;
    int n;
    int t [3];

    tick_exp = '{8'h50, 8'hA8, 8'hD4, 8'h6A};
    b2b_exp  = '{2'b10, 2'b10, 2'b00};

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'(state_out), 32'h A1);
    chk("reset_sym", 32'(sym), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_sym_valid", 32'(sym_valid), 32'h0);
    chk("reset_lockup", 32'(lockup), 32'h0);

    // free-running ticks
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tick_state", 32'(state_out), 32'(tick_exp[i]));
    end
    tick = 1'b0;

    // single request; ticks held high during STEP must not add shifts
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(2'b10);
    req = 1'b1;
    @(negedge clk);
    req  = 1'b0;
    tick = 1'b1;
    bc   = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1) bc++;
      if (i == 3) tick = 1'b0;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(bc), 32'd4);
    chk("req_state", 32'(state_out), 32'h6A);
    chk("req_sym_held", 32'(sym), 32'h2);

    // load of zero recovers to SEED with a one-cycle lockup pulse
    load = 1'b1;
    load_value = 8'h00;
    @(negedge clk);
    load = 1'b0;
    chk("load0_state", 32'(state_out), 32'hA1);
    chk("load0_lockup", 32'(lockup), 32'h1);
    @(negedge clk);
    chk("load0_lockup_clear", 32'(lockup), 32'h0);

    // load mid-STEP aborts the request silently
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    load = 1'b1;
    load_value = 8'h3C;
    @(negedge clk);
    load = 1'b0;
    chk("abort_state", 32'(state_out), 32'h3C);
    chk("abort_busy", 32'(busy), 32'h0);
    repeat (6) @(negedge clk);
    chk("abort_state_idle", 32'(state_out), 32'h3C);
    chk("abort_sym_kept", 32'(sym), 32'h2);

    // reset beats load and req on the same edge
    rst = 1'b1;
    load = 1'b1;
    load_value = 8'h55;
    req = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    chk("rst_prio_state", 32'(state_out), 32'hA1);
    chk("rst_prio_busy", 32'(busy), 32'h0);
    chk("rst_prio_sym", 32'(sym), 32'h0);
    rst = 1'b0;
    load = 1'b0;
    tick = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(b2b_exp[i]);

    // req held high: back-to-back symbols
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sym_valid === 1'b1) begin
        t[n] = cyc;
        n++;
        if (n == 3) begin
          req = 1'b0;
          break;
        end
      end
    end
    req = 1'b0;
    chk("b2b_count", 32'(n), 32'd3);
    if (n == 3) begin
      chk("b2b_gap1", 32'(t[1] - t[0]), 32'd5);
      chk("b2b_gap2", 32'(t[2] - t[1]), 32'd5);
    end
    chk("b2b_state", 32'(state_out), 32'h38);

`ifdef LFSR_REPLAY_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mark = 1'b1;
    @(negedge clk);
    mark = 1'b0;
    run_three_reqs();
    chk("pre_replay_state", 32'(state_out), 32'h38);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    chk("replay_state", 32'(state_out), 32'hA1);
    run_three_reqs();
    mark = 1'b1;
    replay = 1'b1;
    @(negedge clk);
    mark = 1'b0;
    replay = 1'b0;
    chk("mark_replay_state", 32'(state_out), 32'hA1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("post_tick_state", 32'(state_out), 32'h50);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    chk("shadow_kept", 32'(state_out), 32'hA1);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
